uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flops in the rx input synchronizer, minimum 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 arst  input  1  reset, asynchronous and active-high.
REQ-004 rst  input  1  synchronous active-high clear, same effect as arst but taken on a clk edge.
REQ-005 rx_en  input  1  receiver enable; gates start-bit detection only.
REQ-006 Load_Value  input  10  clk cycles per bit period (baud divisor).
REQ-007 Rx  input  1  serial line, asynchronous to clk, idle high.
REQ-008 data  output  8  last correctly framed byte received.
REQ-009 done  output  1  one-cycle pulse when data is updated.
REQ-010 busy  output  1  high while a frame is in progress.
REQ-011 frame_err  output  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-012 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-013 Rx SHALL pass through a SYNC_STAGES synchronizer; all logic SHALL use only the synchronized value rx_s and its one-cycle-delayed copy rx_d.
REQ-014 The FSM SHALL have exactly four states: IDLE, START, DATA and STOP.
REQ-015 IDLE->START SHALL occur only when rx_en=1, rx_d=1 and rx_s=0 (a falling edge), and SHALL clear the bit-period counter.
REQ-016 Load_Value SHALL be captured into an internal register on the IDLE->START transition and used for the whole frame; a captured value below 4 SHALL be replaced by 4.
REQ-017 The bit-period counter SHALL count 0..P-1, where P is the captured divisor, and SHALL restart at 0 after every sample point.
REQ-018 In START, rx_s SHALL be sampled when the counter equals (P>>1)-1.
REQ-019 If the START sample is 1, the frame is a false start: the FSM SHALL return to IDLE with no done and no frame_err.
REQ-020 If the START sample is 0, the FSM SHALL enter DATA with the bit index at 0.
REQ-021 In DATA, rx_s SHALL be sampled at counter P-1 into shift-register bit [index], LSB first.
REQ-022 After the sample for index 7, the FSM SHALL enter STOP.
REQ-023 In STOP, rx_s SHALL be sampled at counter P-1.
REQ-024 If the STOP sample is 1, data SHALL load the shift register and done SHALL pulse high for one cycle, both on the clk edge after the sample cycle.
REQ-025 If the STOP sample is 0, frame_err SHALL pulse for one cycle at the same point and data SHALL hold its previous value.
REQ-026 Both STOP outcomes SHALL return the FSM to IDLE.
REQ-027 After a frame error, a new start SHALL require a fresh falling edge, so a line held low SHALL NOT retrigger reception.
REQ-028 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-029 Deasserting rx_en mid-frame SHALL NOT abort the frame; it only blocks the next start.
REQ-030 done and frame_err SHALL never be high in the same cycle.
REQ-031 A falling edge arriving in the same cycle the FSM returns to IDLE SHALL be ignored; detection resumes on the following cycle.

Reset
REQ-032 On arst=1 (asynchronously) or rst=1 (at a clk edge), all outputs and state SHALL take these values: FSM=IDLE, counters=0, data=8'h00, done=0, busy=0, frame_err=0, and all synchronizer flops and rx_d=1.
REQ-033 Reset asserted mid-frame SHALL discard the partial byte with no done or frame_err pulse; reception SHALL resume only on a new falling edge after reset release.

Verification
REQ-034 Load_Value=650, rx_en=1, frame 8'h35 driven with 6500-ns bits at a 10 ns clk -> exactly one done pulse about 6175 cycles after rx_s falls, data=8'h35, busy high throughout, frame_err=0.
REQ-035 Same setup with the stop bit driven 0 -> one frame_err pulse, no done, data unchanged (8'h00 from reset), FSM in IDLE; Rx held low afterwards -> busy stays 0.
REQ-036 Rx low for 100 cycles then high, Load_Value=650 -> busy high for 325 cycles then 0, with no done and no frame_err.
REQ-037 Back-to-back frames 8'hA5 then 8'h5A with zero idle gap -> two done pulses, data=8'hA5 then 8'h5A.
REQ-038 arst pulsed mid-DATA -> outputs immediately at reset values, no pulse; the next full frame 8'hFF is received correctly.
REQ-039 Load_Value=2 with 4-cycle bits, frame 8'h81 -> data=8'h81; also rx_en=0 during a start edge -> no reception.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - control, serial line and status bundle for uart_rx
`timescale 1ns/1ps
interface uart_rx_if;
  logic       rx_en;
  logic [9:0] Load_Value;
  logic       Rx;
  logic [7:0] data;
  logic       done;
  logic       busy;
  logic       frame_err;

  modport slave (
    input  rx_en, Load_Value, Rx,
    output data, done, busy, frame_err
  );

  modport master (
    output rx_en, Load_Value, Rx,
    input  data, done, busy, frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with input synchronizer and per-frame baud divisor
`timescale 1ns/1ps
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     arst,
  input  logic     rst,
  uart_rx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_d_q, rx_d_d;
  logic [9:0]             cnt_q, cnt_d;
  logic [9:0]             div_q, div_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;

  logic       rx_s;
  logic [9:0] limit;
  logic       at_sample;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  // START samples mid-bit; every later sample is one full period after the previous one
  assign limit     = (state_q == START) ? ((div_q >> 1) - 10'd1) : (div_q - 10'd1);
  assign at_sample = (cnt_q == limit);

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.Rx};
    rx_d_d  = rx_s;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = at_sample ? 10'd0 : cnt_q + 10'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.rx_en && rx_d_q && !rx_s) begin
          state_d = START;
          cnt_d   = 10'd0;
          div_d   = (bus.Load_Value < 10'd4) ? 10'd4 : bus.Load_Value;
        end
      end
      START: begin
        if (at_sample) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = 3'd0;
          end
        end
      end
      DATA: begin
        if (at_sample) begin
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (at_sample) begin
          state_d = IDLE;
          if (rx_s) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Synchronous clear overrides everything computed above
    if (rst) begin
      state_d = IDLE;
      sync_d  = '1;
      rx_d_d  = 1'b1;
      cnt_d   = 10'd0;
      div_d   = 10'd0;
      idx_d   = 3'd0;
      shift_d = 8'h00;
      data_d  = 8'h00;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      sync_q  <= '1;
      rx_d_q  <= 1'b1;
      cnt_q   <= 10'd0;
      div_q   <= 10'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      rx_d_q  <= rx_d_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.done      = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed table-driven bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

  logic clk = 1'b0;
  logic arst;
  logic rst;

  uart_rx_if u_if();

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk  (clk),
    .arst (arst),
    .rst  (rst),
    .bus  (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int   done_cnt   = 0;
  int   ferr_cnt   = 0;
  int   both_cnt   = 0;
  int   busy_rises = 0;
  int   busy_run   = 0;
  int   last_run   = 0;
  logic prev_busy  = 1'b0;
  logic [7:0] done_data[$];

  always @(negedge clk) begin
    if (u_if.done) begin
      done_cnt++;
      done_data.push_back(u_if.data);
    end
    if (u_if.frame_err) ferr_cnt++;
    if (u_if.done && u_if.frame_err) both_cnt++;
    if (u_if.busy && !prev_busy) busy_rises++;
    if (u_if.busy) begin
      busy_run++;
    end else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
    prev_busy = u_if.busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    u_if.Rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int n, input logic stop);
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(b[i], n);
    drive_bit(stop, n);
  endtask

  typedef struct {
    logic [9:0] load;
    int         bitc;
    logic       en;
    logic [7:0] b;
    logic       stop;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_data;
    int         exp_run;
  } vec_t;

  vec_t vecs[8];

  int d0, f0, r0;
  logic [7:0] got;

  initial begin
    vecs[0] = '{10'd650, 650, 1'b1, 8'h35, 1'b0, 0, 1, 8'h00, 6175};
    vecs[1] = '{10'd650, 650, 1'b1, 8'h35, 1'b1, 1, 0, 8'h35, 6175};
    vecs[2] = '{10'd2,   4,   1'b1, 8'h81, 1'b1, 1, 0, 8'h81, 38};
    vecs[3] = '{10'd2,   4,   1'b0, 8'h3C, 1'b1, 0, 0, 8'h81, 0};
    vecs[4] = '{10'd16,  16,  1'b1, 8'h00, 1'b1, 1, 0, 8'h00, 152};
    vecs[5] = '{10'd16,  16,  1'b1, 8'hFF, 1'b0, 0, 1, 8'h00, 152};
    vecs[6] = '{10'd3,   4,   1'b1, 8'hC3, 1'b1, 1, 0, 8'hC3, 38};
    vecs[7] = '{10'd10,  10,  1'b1, 8'hA5, 1'b1, 1, 0, 8'hA5, 95};

    arst = 1'b1;
    rst  = 1'b0;
    u_if.Rx         = 1'b1;
    u_if.rx_en      = 1'b0;
    u_if.Load_Value = 10'd650;
    #23;
    check("reset data", u_if.data, 8'h00);
    check("reset done", u_if.done, 1'b0);
    check("reset busy", u_if.busy, 1'b0);
    check("reset frame_err", u_if.frame_err, 1'b0);
    #4 arst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt; f0 = ferr_cnt; r0 = busy_rises;
      u_if.Load_Value = vecs[i].load;
      u_if.rx_en      = vecs[i].en;
      send_frame(vecs[i].b, vecs[i].bitc, vecs[i].stop);
      drive_bit(vecs[i].stop, 2 * vecs[i].bitc + 8);
      drive_bit(1'b1, 8);
      #1;
      check($sformatf("vec%0d done count", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("vec%0d frame_err count", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d data", i), u_if.data, vecs[i].exp_data);
      check($sformatf("vec%0d busy starts", i), busy_rises - r0, vecs[i].en ? 1 : 0);
      check($sformatf("vec%0d busy idle", i), u_if.busy, 1'b0);
      if (vecs[i].en) check($sformatf("vec%0d busy length", i), last_run, vecs[i].exp_run);
    end

    // false start: short low pulse
    d0 = done_cnt; f0 = ferr_cnt; r0 = busy_rises;
    u_if.Load_Value = 10'd650;
    u_if.rx_en      = 1'b1;
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 700);
    #1;
    check("false start busy starts", busy_rises - r0, 1);
    check("false start busy length", last_run, 325);
    check("false start done", done_cnt - d0, 0);
    check("false start frame_err", ferr_cnt - f0, 0);

    // back-to-back frames, no idle gap
    d0 = done_cnt; f0 = ferr_cnt;
    u_if.Load_Value = 10'd16;
    send_frame(8'hA5, 16, 1'b1);
    send_frame(8'h5A, 16, 1'b1);
    drive_bit(1'b1, 40);
    #1;
    check("b2b done count", done_cnt - d0, 2);
    got = (done_data.size() > d0) ? done_data[d0] : 8'hxx;
    check("b2b first data", got, 8'hA5);
    got = (done_data.size() > d0 + 1) ? done_data[d0 + 1] : 8'hxx;
    check("b2b second data", got, 8'h5A);
    check("b2b frame_err", ferr_cnt - f0, 0);

    // async reset mid-DATA
    d0 = done_cnt; f0 = ferr_cnt; r0 = busy_rises;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 40);
    #3 arst = 1'b1;
    #1;
    check("arst busy", u_if.busy, 1'b0);
    check("arst data", u_if.data, 8'h00);
    check("arst done", u_if.done, 1'b0);
    check("arst frame_err", u_if.frame_err, 1'b0);
    #4 arst = 1'b0;
    @(negedge clk);
    drive_bit(1'b1, 200);
    #1;
    check("arst no pulse done", done_cnt - d0, 0);
    check("arst no pulse frame_err", ferr_cnt - f0, 0);
    check("arst no restart", busy_rises - r0, 1);
    send_frame(8'hFF, 16, 1'b1);
    drive_bit(1'b1, 40);
    #1;
    check("after arst done count", done_cnt - d0, 1);
    check("after arst data", u_if.data, 8'hFF);

    // synchronous clear mid-frame
    d0 = done_cnt; f0 = ferr_cnt;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 32);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst busy", u_if.busy, 1'b0);
    check("rst data", u_if.data, 8'h00);
    @(negedge clk);
    drive_bit(1'b1, 200);
    #1;
    check("rst no pulse", (done_cnt - d0) + (ferr_cnt - f0), 0);
    send_frame(8'h96, 16, 1'b1);
    drive_bit(1'b1, 40);
    #1;
    check("after rst data", u_if.data, 8'h96);

    // rx_en dropped mid-frame still completes, then blocks the next start
    d0 = done_cnt; r0 = busy_rises;
    drive_bit(1'b0, 16);
    u_if.rx_en = 1'b0;
    for (int i = 0; i < 8; i++) drive_bit(((8'h6C >> i) & 8'h01) != 0, 16);
    drive_bit(1'b1, 40);
    #1;
    check("en drop done", done_cnt - d0, 1);
    check("en drop data", u_if.data, 8'h6C);
    send_frame(8'h12, 16, 1'b1);
    drive_bit(1'b1, 40);
    #1;
    check("en low done", done_cnt - d0, 1);
    check("en low busy starts", busy_rises - r0, 1);
    check("en low data", u_if.data, 8'h6C);

    check("done and frame_err overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
